// File: rtl/cordic_link_pkg.sv
// Shared types and constants for the host side of the CORDIC byte link.
package cordic_link_pkg;

  typedef enum logic [1:0] {StIdle, StTx, StRx, StRsp} state_e;

  localparam int unsigned TX_BYTES = 4;
  localparam int unsigned RX_BYTES = 6;
  localparam int unsigned DEFAULT_TIMEOUT_CYC = 1024;

  // Byte positions on the link, least significant byte first.
  localparam logic [2:0] IdxXLo  = 3'd0;
  localparam logic [2:0] IdxXHi  = 3'd1;
  localparam logic [2:0] IdxYLo  = 3'd2;
  localparam logic [2:0] IdxYHi  = 3'd3;
  localparam logic [2:0] IdxMagLo   = 3'd0;
  localparam logic [2:0] IdxPhaseLo = 3'd2;

  function automatic logic [7:0] tx_byte(logic [15:0] x, logic [15:0] y, logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      IdxXLo:  b = x[7:0];
      IdxXHi:  b = x[15:8];
      IdxYLo:  b = y[7:0];
      IdxYHi:  b = y[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cordic_link_watchdog.sv
// Link inactivity counter: fires once LIMIT counted cycles pass without a clear.
module cordic_link_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(LIMIT) + 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Fires on the cycle whose increment would reach LIMIT.
  assign expired = en && !clear && (cnt_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/cordic_link_host.sv
// Host endpoint of the CORDIC byte link: 4-byte request out, 6-byte reply in.
// Optional watchdog abort enabled by defining CORDIC_HOST_TIMEOUT_EN.
module cordic_link_host
  import cordic_link_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PHASE_W     = 32,
  parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_x,
  input  logic [WIDTH-1:0]   req_y,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_mag,
  output logic [PHASE_W-1:0] rsp_phase,
  output logic               rsp_timeout,
  output logic [7:0]         link_data_out,
  output logic               link_in_valid,
  input  logic               link_in_ready,
  input  logic [7:0]         link_data_in,
  input  logic               link_out_valid,
  output logic               link_out_ready
);

  localparam logic [2:0] TxLast = 3'(TX_BYTES - 1);
  localparam logic [2:0] RxLast = 3'(RX_BYTES - 1);

  state_e state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic [39:0]        rx_buf_q, rx_buf_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               in_valid_q, in_valid_d;
  logic               out_ready_q, out_ready_d;
  logic               tx_hs, rx_hs;

  assign tx_hs = in_valid_q && link_in_ready;
  assign rx_hs = out_ready_q && link_out_valid;

`ifdef CORDIC_HOST_TIMEOUT_EN
  logic wd_clear, wd_en, wd_expired;

  assign wd_en    = (state_q == StTx) || (state_q == StRx);
  assign wd_clear = ((state_q == StIdle) && req_valid) || tx_hs || rx_hs;

  cordic_link_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (wd_clear),
    .en     (wd_en),
    .expired(wd_expired)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    x_d           = x_q;
    y_d           = y_q;
    rx_buf_d      = rx_buf_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_timeout_d = rsp_timeout_q;
    mag_d         = mag_q;
    phase_d       = phase_q;
    data_out_d    = data_out_q;
    in_valid_d    = in_valid_q;
    out_ready_d   = out_ready_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          x_d         = req_x;
          y_d         = req_y;
          req_ready_d = 1'b0;
          data_out_d  = tx_byte(req_x, req_y, IdxXLo);
          in_valid_d  = 1'b1;
          idx_d       = '0;
          state_d     = StTx;
        end
      end
      StTx: begin
        if (tx_hs) begin
          if (idx_q == TxLast) begin
            in_valid_d  = 1'b0;
            out_ready_d = 1'b1;
            idx_d       = IdxMagLo;
            state_d     = StRx;
          end else begin
            idx_d      = idx_q + 3'd1;
            data_out_d = tx_byte(x_q, y_q, idx_q + 3'd1);
          end
        end
      end
      StRx: begin
        if (rx_hs) begin
          if (idx_q == RxLast) begin
            // Final phase byte goes straight to the output register.
            mag_d         = rx_buf_q[15:0];
            phase_d       = {link_data_in, rx_buf_q[39:8*IdxPhaseLo]};
            out_ready_d   = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b0;
            idx_d         = '0;
            state_d       = StRsp;
          end else begin
            rx_buf_d[{idx_q, 3'b000} +: 8] = link_data_in;
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef CORDIC_HOST_TIMEOUT_EN
    if (wd_expired) begin
      in_valid_d    = 1'b0;
      out_ready_d   = 1'b0;
      mag_d         = '0;
      phase_d       = '0;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
      idx_d         = '0;
      state_d       = StRsp;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      rx_buf_q      <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      mag_q         <= '0;
      phase_q       <= '0;
      data_out_q    <= '0;
      in_valid_q    <= 1'b0;
      out_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rx_buf_q      <= rx_buf_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      mag_q         <= mag_d;
      phase_q       <= phase_d;
      data_out_q    <= data_out_d;
      in_valid_q    <= in_valid_d;
      out_ready_q   <= out_ready_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign rsp_mag        = mag_q;
  assign rsp_phase      = phase_q;
  assign link_data_out  = data_out_q;
  assign link_in_valid  = in_valid_q;
  assign link_out_ready = out_ready_q;

endmodule
